// File: rtl/opc5_pkg.sv
// Shared types and constants for the OPC5 serial boot loader.
package opc5_pkg;

  // Header and data states are numbered in frame order so a byte simply steps to the next state.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LEN_HI = 4'd1,
    ST_LEN_LO = 4'd2,
    ST_ADR_HI = 4'd3,
    ST_ADR_LO = 4'd4,
    ST_DAT_HI = 4'd5,
    ST_DAT_LO = 4'd6,
    ST_WRITE  = 4'd7,
    ST_CSUM   = 4'd8,
    ST_RUN    = 4'd9
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic logic in_frame(state_t s);
    return (s != ST_IDLE) && (s != ST_RUN);
  endfunction

endpackage

// File: rtl/opc5_byte_timeout.sv
// Inter-byte watchdog: reloads on every received byte, ticks once the idle budget is spent.
module opc5_byte_timeout #(
  parameter int TIMEOUT = 3200000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic tick
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] RELOAD = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_r;

  // Down-counter: a byte reloads it, it then drains while a frame is open.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= RELOAD;
    end else if (enable && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = enable && !load && (cnt_r == '0);

endmodule

// File: rtl/opc5_boot_loader.sv
// OPC5 boot sequencer: loads a framed UART image into RAM, then hands the RAM port to the CPU.
module opc5_boot_loader
  import opc5_pkg::*;
#(
  parameter int         RAMSIZE = 11,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter int         TIMEOUT = 3200000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               boot_skip,
  input  logic [15:0]        cpu_address,
  input  logic [15:0]        cpu_dout,
  input  logic               cpu_rnw,
  input  logic               cpu_ram_cs_b,
  output logic [RAMSIZE-1:0] ram_address,
  output logic [15:0]        ram_din,
  output logic               ram_rnw,
  output logic               ram_cs_b,
  output logic               cpu_reset_b,
  output logic               busy,
  output logic               error
);

  state_t      state_r, state_nx;
  logic [15:0] len_r, addr_r;
  logic [7:0]  hi_r, lo_r, sum_r, hold_data_r;
  logic        hold_valid_r, hold_valid_nx;
  logic        error_r, cpu_reset_b_r;
  logic        in_valid, consume, set_err, hold_ovf, tick;
  logic [7:0]  in_data, sum_add;
  logic        unused_cpu_hi;

  // A byte parked during WRITE is served before the live input.
  assign in_valid = hold_valid_r | rx_valid;
  assign in_data  = hold_valid_r ? hold_data_r : rx_data;
  assign sum_add  = sum_r + in_data;
  assign consume  = in_valid && (state_r != ST_WRITE) && (state_r != ST_RUN);
  assign hold_ovf = (state_r == ST_WRITE) && rx_valid && hold_valid_r;
  assign unused_cpu_hi = ^cpu_address[15:RAMSIZE];

  opc5_byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .load   (rx_valid),
    .enable (in_frame(state_r)),
    .tick   (tick)
  );

  // Frame FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state decode; a received byte always wins over a same-cycle timeout.
  always_comb begin
    state_nx = state_r;
    set_err  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (boot_skip) begin
          state_nx = ST_RUN;
        end else if (in_valid && (in_data == SYNC)) begin
          state_nx = ST_LEN_HI;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_LEN_HI, ST_LEN_LO, ST_ADR_HI, ST_DAT_HI, ST_DAT_LO: begin
        if (in_valid) begin
          state_nx = state_t'(state_r + 4'd1);
        end else if (tick) begin
          state_nx = ST_IDLE;
          set_err  = 1'b1;
        end else begin
          state_nx = state_r;
        end
      end
      ST_ADR_LO: begin
        if (in_valid) begin
          state_nx = (len_r != 16'd0) ? ST_DAT_HI : ST_CSUM;
        end else if (tick) begin
          state_nx = ST_IDLE;
          set_err  = 1'b1;
        end else begin
          state_nx = state_r;
        end
      end
      ST_WRITE: begin
        if (tick) begin
          state_nx = ST_IDLE;
          set_err  = 1'b1;
        end else if (len_r == 16'd1) begin
          state_nx = ST_CSUM;
        end else begin
          state_nx = ST_DAT_HI;
        end
      end
      ST_CSUM: begin
        if (in_valid) begin
          state_nx = (sum_add == 8'd0) ? ST_RUN : ST_IDLE;
          set_err  = (sum_add != 8'd0);
        end else if (tick) begin
          state_nx = ST_IDLE;
          set_err  = 1'b1;
        end else begin
          state_nx = state_r;
        end
      end
      ST_RUN: begin
        state_nx = ST_RUN;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Holding register occupancy; emptied whenever the frame ends.
  always_comb begin
    hold_valid_nx = 1'b0;
    if ((state_nx == ST_IDLE) || (state_nx == ST_RUN)) begin
      hold_valid_nx = 1'b0;
    end else if (state_r == ST_WRITE) begin
      hold_valid_nx = hold_valid_r | rx_valid;
    end else if (hold_valid_r) begin
      hold_valid_nx = rx_valid;
    end else begin
      hold_valid_nx = 1'b0;
    end
  end

  // Frame datapath: header/data capture, running checksum, write address and word count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r         <= 16'd0;
      addr_r        <= 16'd0;
      hi_r          <= 8'd0;
      lo_r          <= 8'd0;
      sum_r         <= 8'd0;
      hold_data_r   <= 8'd0;
      hold_valid_r  <= 1'b0;
      error_r       <= 1'b0;
      cpu_reset_b_r <= 1'b0;
    end else begin
      hold_valid_r  <= hold_valid_nx;
      error_r       <= error_r | set_err | hold_ovf;
      cpu_reset_b_r <= (state_r == ST_RUN);
      if (rx_valid && (((state_r == ST_WRITE) && !hold_valid_r) ||
                       ((state_r != ST_WRITE) && hold_valid_r))) begin
        hold_data_r <= rx_data;
      end
      if (consume) begin
        case (state_r)
          ST_IDLE:   sum_r <= 8'd0;
          ST_LEN_HI: begin len_r[15:8]  <= in_data; sum_r <= sum_add; end
          ST_LEN_LO: begin len_r[7:0]   <= in_data; sum_r <= sum_add; end
          ST_ADR_HI: begin addr_r[15:8] <= in_data; sum_r <= sum_add; end
          ST_ADR_LO: begin addr_r[7:0]  <= in_data; sum_r <= sum_add; end
          ST_DAT_HI: begin hi_r         <= in_data; sum_r <= sum_add; end
          ST_DAT_LO: begin lo_r         <= in_data; sum_r <= sum_add; end
          ST_CSUM:   sum_r <= sum_add;
          default:   sum_r <= sum_r;
        endcase
      end else if (state_r == ST_WRITE) begin
        addr_r <= addr_r + 16'd1;
        len_r  <= len_r - 16'd1;
      end
    end
  end

  // RAM port arbiter: the CPU owns the port combinationally once running.
  always_comb begin
    if (state_r == ST_RUN) begin
      ram_address = cpu_address[RAMSIZE-1:0];
      ram_din     = cpu_dout;
      ram_rnw     = cpu_rnw;
      ram_cs_b    = cpu_ram_cs_b;
    end else begin
      ram_address = addr_r[RAMSIZE-1:0];
      ram_din     = {hi_r, lo_r};
      ram_rnw     = (state_r != ST_WRITE);
      ram_cs_b    = (state_r != ST_WRITE);
    end
  end

  assign busy        = (state_r != ST_RUN);
  assign cpu_reset_b = cpu_reset_b_r;
  assign error       = error_r;

endmodule

// File: tb/tb_opc5_boot_loader.sv
// Randomised frame stimulus for opc5_boot_loader checked against a frame-level model.
module tb_opc5_boot_loader;

  localparam int RAMSIZE = 11;
  localparam int TIMEOUT = 100;

  logic               clk, reset, rx_valid, boot_skip, cpu_rnw, cpu_ram_cs_b;
  logic [7:0]         rx_data;
  logic [15:0]        cpu_address, cpu_dout, ram_din;
  logic [RAMSIZE-1:0] ram_address;
  logic               ram_rnw, ram_cs_b, cpu_reset_b, busy, error;

  opc5_boot_loader #(.RAMSIZE(RAMSIZE), .SYNC(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .boot_skip(boot_skip), .cpu_address(cpu_address), .cpu_dout(cpu_dout),
    .cpu_rnw(cpu_rnw), .cpu_ram_cs_b(cpu_ram_cs_b), .ram_address(ram_address),
    .ram_din(ram_din), .ram_rnw(ram_rnw), .ram_cs_b(ram_cs_b),
    .cpu_reset_b(cpu_reset_b), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [10:0] a; logic [15:0] d; } wr_t;

  int          n_cmp = 0;
  int          n_err = 0;
  wr_t         exp_wq[$];
  logic        exp_busy, exp_rst_b, exp_error, chk_en;
  logic [15:0] wbuf [0:7];
  logic [15:0] ram [0:2047];
  logic [7:0]  cs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // External block RAM, written by whoever owns the port.
  always @(posedge clk) begin
    if (!ram_cs_b && !ram_rnw) ram[ram_address] <= ram_din;
  end

  // Per-cycle compare against the model's status flags and expected write list.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("cpu_reset_b", 32'(cpu_reset_b), 32'(exp_rst_b));
      check("error", 32'(error), 32'(exp_error));
      if (busy && !ram_cs_b && !ram_rnw) begin
        if (exp_wq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write addr=%h data=%h expected no write", ram_address, ram_din);
        end else begin
          wr_t w;
          w = exp_wq.pop_front();
          check("wr_addr", 32'(ram_address), 32'(w.a));
          check("wr_data", 32'(ram_din), 32'(w.d));
        end
      end
    end
  end

  task automatic do_reset();
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1; rx_valid = 1'b0; boot_skip = 1'b0;
    cpu_ram_cs_b = 1'b1; cpu_rnw = 1'b1; cpu_address = 16'h0; cpu_dout = 16'h0;
    #1;
    check("rst_ram_cs_b", 32'(ram_cs_b), 32'd1);
    check("rst_ram_rnw", 32'(ram_rnw), 32'd1);
    check("rst_ram_address", 32'(ram_address), 32'd0);
    check("rst_ram_din", 32'(ram_din), 32'd0);
    check("rst_cpu_reset_b", 32'(cpu_reset_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_error", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_busy = 1'b1; exp_rst_b = 1'b0; exp_error = 1'b0;
    exp_wq.delete();
    chk_en = 1'b1;
  endtask

  // Byte is sampled on the posedge ending its one-cycle strobe; returns just after that edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_garbage(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b, $urandom_range(1, 3));
    end
  endtask

  // Model: builds the frame from wbuf, predicts the RAM writes and the outcome.
  task automatic send_frame(input logic [15:0] len, input logic [15:0] addr,
                            input int bad_delta, output logic [7:0] csum);
    logic [7:0] bytes[$];
    logic [7:0] sum;
    int         gap;
    bytes = {};
    bytes.push_back(8'hA5);
    bytes.push_back(len[15:8]);
    bytes.push_back(len[7:0]);
    bytes.push_back(addr[15:8]);
    bytes.push_back(addr[7:0]);
    for (int i = 0; i < int'(len); i++) begin
      bytes.push_back(wbuf[i][15:8]);
      bytes.push_back(wbuf[i][7:0]);
      exp_wq.push_back('{a: 11'(addr + 16'(i)), d: wbuf[i]});
    end
    sum = 8'd0;
    for (int k = 1; k < bytes.size(); k++) sum = sum + bytes[k];
    csum = 8'd0 - sum + 8'(bad_delta);
    bytes.push_back(csum);
    for (int k = 0; k < bytes.size(); k++) begin
      gap = $urandom_range(1, 3);
      // a data high byte right after a low byte lands in the WRITE cycle
      if (k >= 7 && k < bytes.size() - 1 && (k % 2) == 1 && $urandom_range(0, 1) == 1) gap = 0;
      send_byte(bytes[k], gap);
    end
    if (bad_delta == 0) begin
      exp_busy = 1'b0;
      @(posedge clk);
      #1;
      exp_rst_b = 1'b1;
    end else begin
      exp_error = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    check(name, 32'(exp_wq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; boot_skip = 1'b0;
    cpu_address = 16'h0; cpu_dout = 16'h0; cpu_rnw = 1'b1; cpu_ram_cs_b = 1'b1;
    chk_en = 1'b0; exp_busy = 1'b1; exp_rst_b = 1'b0; exp_error = 1'b0;

    // Reference frame, good checksum.
    do_reset();
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
    send_frame(16'd2, 16'h0010, 0, cs);
    check("A_csum_model", 32'(cs), 32'h30);
    drain("A_writes_done");
    check("A_ram10", 32'(ram[11'h010]), 32'h1234);
    check("A_ram11", 32'(ram[11'h011]), 32'hABCD);
    check("A_error", 32'(error), 32'd0);
    check("A_cpu_reset_b", 32'(cpu_reset_b), 32'd1);

    // Same frame with CSUM+1: words still written, error, stays in loader.
    do_reset();
    send_frame(16'd2, 16'h0010, 1, cs);
    drain("B_writes_done");
    check("B_error", 32'(error), 32'd1);
    check("B_busy", 32'(busy), 32'd1);
    check("B_cpu_reset_b", 32'(cpu_reset_b), 32'd0);

    // Zero-length frame: straight to RUN with no write strobe.
    do_reset();
    send_frame(16'd0, 16'h0000, 0, cs);
    drain("C_writes_done");
    check("C_busy", 32'(busy), 32'd0);

    // RAM index wrap at 2^RAMSIZE.
    do_reset();
    wbuf[0] = 16'($urandom); wbuf[1] = 16'($urandom);
    send_frame(16'd2, 16'h07FF, 0, cs);
    drain("D_writes_done");
    check("D_ram7ff", 32'(ram[11'h7FF]), 32'(wbuf[0]));
    check("D_ram000", 32'(ram[11'h000]), 32'(wbuf[1]));

    // Inter-byte timeout after the header, then a good frame with error still set.
    do_reset();
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h02, 1);
    send_byte(8'h00, 1); send_byte(8'h10, 1);
    repeat (TIMEOUT - 1) @(posedge clk);
    @(negedge clk);
    check("E_err_at_99", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    exp_error = 1'b1;
    @(negedge clk);
    check("E_err_at_100", 32'(error), 32'd1);
    check("E_busy_at_100", 32'(busy), 32'd1);
    wbuf[0] = 16'($urandom);
    send_frame(16'd1, 16'h0123, 0, cs);
    drain("E_writes_done");
    check("E_error_sticky", 32'(error), 32'd1);
    check("E_cpu_reset_b", 32'(cpu_reset_b), 32'd1);

    // boot_skip beats a same-cycle SYNC; CPU then owns the RAM port combinationally.
    do_reset();
    @(posedge clk);
    #1;
    boot_skip = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
    @(posedge clk);
    #1;
    boot_skip = 1'b0; rx_valid = 1'b0;
    exp_busy = 1'b0;
    @(posedge clk);
    #1;
    exp_rst_b = 1'b1;
    cpu_rnw = 1'b0; cpu_ram_cs_b = 1'b0; cpu_address = 16'h0005; cpu_dout = 16'($urandom);
    #1;
    check("F_ram_address", 32'(ram_address), 32'h005);
    check("F_ram_cs_b", 32'(ram_cs_b), 32'd0);
    check("F_ram_rnw", 32'(ram_rnw), 32'd0);
    check("F_ram_din", 32'(ram_din), 32'(cpu_dout));
    @(posedge clk);
    #1;
    cpu_rnw = 1'b1; cpu_ram_cs_b = 1'b1;
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h01, 1);
    drain("F_no_writes");

    // Randomised sessions: garbage, failed frames, then usually a good one.
    for (int it = 0; it < 8; it++) begin
      int nfr;
      do_reset();
      nfr = $urandom_range(1, 3);
      for (int f = 0; f < nfr; f++) begin
        int          bd;
        logic [15:0] ln, ad;
        send_garbage($urandom_range(0, 2));
        ln = 16'($urandom_range(0, 5));
        ad = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
        for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
        bd = (f < nfr - 1 || $urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
        send_frame(ln, ad, bd, cs);
      end
      drain("R_writes_done");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
